instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 38 +++
 rtl/instruction_fetch_if_id_reg.sv | 41 ++++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: opcode constants,
// fetch FSM state encoding, reset/NOP defaults and small PC helpers.
package instruction_fetch_pkg;

  // Opcode field values (Instr[31:26]) seen by the decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  // Fetch controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential address, wraps modulo 2^32
  function automatic logic [31:0] next_pc(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register. Holds on stall, clears to a bubble on flush,
// otherwise captures either the returning memory word or a bubble.
module if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        load_valid,
  input  logic [31:0] data,
  input  logic [31:0] pc_plus4_in,
  output logic [31:0] instr,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  // Flush beats stall so a redirect or halt always leaves a bubble behind
  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= NOP_WORD;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end else if (!stall) begin
      if (load_valid) begin
        instr    <= data;
        pc_plus4 <= pc_plus4_in;
        valid    <= 1'b1;
      end else begin
        instr <= NOP_WORD;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, fetch control FSM and the
// interface to a synchronous instruction memory with one-cycle read latency.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for Start; no memory reads issued
//   ST_RUN    | one read per unstalled cycle, PC advances by 4 per read
//   ST_HALTED | halt opcode reached; frozen until reset
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  input  logic        Halt,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_data,
  output logic [31:0] Instr,
  output logic [31:0] PCPlus4,
  output logic        InstrValid,
  output logic        Halted
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        inflight;
  logic        halted_q;
  logic        fetch_go;
  logic        halt_take;
  logic        ifid_flush;

  // A read is only issued when nothing downstream wants the pipe held or steered
  assign fetch_go   = (state == ST_RUN) && !Stall && !Redirect && !Halt;
  // A halt that arrives together with a redirect came from the wrong path
  assign halt_take  = (state == ST_RUN) && Halt && !Redirect;
  assign ifid_flush = Redirect || halt_take;

  assign imem_en   = fetch_go;
  assign imem_addr = pc;
  assign Halted    = halted_q;

  // Fetch FSM with PC, in-flight tracking and the Halted flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      halted_q <= 1'b0;
    end else if (Redirect) begin
      // Steering only; the word already in flight belongs to the old path
      pc       <= align_word(RedirectPC);
      inflight <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          inflight <= 1'b0;
          if (Start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (Halt) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
            inflight <= 1'b0;
          end else if (!Stall) begin
            inflight <= 1'b1;
            req_pc   <= pc;
            pc       <= next_pc(pc);
          end
        end
        ST_HALTED: begin
          inflight <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          inflight <= 1'b0;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk         (clk),
    .reset       (reset),
    .stall       (Stall),
    .flush       (ifid_flush),
    .load_valid  (inflight),
    .data        (imem_data),
    .pc_plus4_in (next_pc(req_pc)),
    .instr       (Instr),
    .pc_plus4    (PCPlus4),
    .valid       (InstrValid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected IF/ID words are queued as
// stimulus is issued and popped by a monitor whenever decode consumes a word.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        Start;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Halt;
  logic [31:0] imem_addr;
  logic        imem_en;
  logic [31:0] imem_data;
  logic [31:0] Instr;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        Halted;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   errors;
  int   checks;

  instruction_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .Halt       (Halt),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_data  (imem_data),
    .Instr      (Instr),
    .PCPlus4    (PCPlus4),
    .InstrValid (InstrValid),
    .Halted     (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word at byte address a is 0x2000_0000 + a/4
  initial imem_data = 32'h0;
  always @(posedge clk) begin
    if (imem_en) imem_data <= 32'h2000_0000 + {2'b00, imem_addr[31:2]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic [31:0] p4);
    exp_t e;
    e.instr = w;
    e.pc4   = p4;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1; Start = 1'b0; Stall = 1'b0; Redirect = 1'b0;
    RedirectPC = 32'h0; Halt = 1'b0;

    // Monitor: a word is consumed when valid and decode is not stalling
    fork
      forever begin
        @(negedge clk);
        if (InstrValid === 1'b1 && Stall === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h pcplus4 %h, expected none", Instr, PCPlus4);
          end else begin
            e_mon = exp_q.pop_front();
            chk("sb_instr", Instr, e_mon.instr);
            chk("sb_pcplus4", PCPlus4, e_mon.pc4);
          end
        end
      end
    join_none

    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", {31'b0, InstrValid}, 32'd0);
    chk("rst_instr", Instr, 32'h0);
    chk("rst_pcplus4", PCPlus4, 32'h0);
    chk("rst_halted", {31'b0, Halted}, 32'd0);
    chk("rst_en", {31'b0, imem_en}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);

    // Straight-line fetch
    push(32'h2000_0000, 32'd4);
    push(32'h2000_0001, 32'd8);
    push(32'h2000_0002, 32'd12);
    Start = 1'b1; cyc(); Start = 1'b0;
    @(negedge clk);
    chk("run_en", {31'b0, imem_en}, 32'd1);
    chk("run_addr0", imem_addr, 32'h0);
    chk("lat_valid_c1", {31'b0, InstrValid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("lat_valid_c2", {31'b0, InstrValid}, 32'd0);
    chk("run_addr1", imem_addr, 32'h4);
    cyc();
    @(negedge clk);
    chk("first_valid", {31'b0, InstrValid}, 32'd1);
    cyc();

    // Three-cycle stall with word 1 in IF/ID
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_instr", Instr, 32'h2000_0001);
      chk("stall_pcplus4", PCPlus4, 32'd8);
      chk("stall_addr", imem_addr, 32'd12);
      chk("stall_en", {31'b0, imem_en}, 32'd0);
      cyc();
    end
    Stall = 1'b0;
    @(negedge clk);
    chk("unstall_en", {31'b0, imem_en}, 32'd1);
    cyc();
    cyc();

    // Redirect to an unaligned target together with a stall
    push(32'h2000_0010, 32'h44);
    Redirect = 1'b1; RedirectPC = 32'h0000_0043; Stall = 1'b1;
    @(negedge clk);
    chk("pre_redir_instr", Instr, 32'h2000_0003);
    chk("redir_en", {31'b0, imem_en}, 32'd0);
    cyc();
    Redirect = 1'b0; Stall = 1'b0;
    @(negedge clk);
    chk("redir_valid", {31'b0, InstrValid}, 32'd0);
    chk("redir_instr", Instr, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_en_after", {31'b0, imem_en}, 32'd1);
    cyc();
    @(negedge clk);
    chk("redir_bubble", {31'b0, InstrValid}, 32'd0);
    push(32'h2000_0011, 32'h48);
    cyc();
    cyc();

    // Halt
    Halt = 1'b1;
    @(negedge clk);
    chk("halt_en", {31'b0, imem_en}, 32'd0);
    cyc();
    Halt = 1'b0;
    @(negedge clk);
    chk("halted", {31'b0, Halted}, 32'd1);
    chk("halt_valid", {31'b0, InstrValid}, 32'd0);
    chk("halt_en2", {31'b0, imem_en}, 32'd0);
    chk("halt_pc", imem_addr, 32'h4C);
    Start = 1'b1; cyc(); Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("halt_start_ign", {31'b0, Halted}, 32'd1);
      chk("halt_start_en", {31'b0, imem_en}, 32'd0);
      chk("halt_start_val", {31'b0, InstrValid}, 32'd0);
      cyc();
    end
    Redirect = 1'b1; RedirectPC = 32'h0000_0101; cyc(); Redirect = 1'b0;
    @(negedge clk);
    chk("halt_redir_addr", imem_addr, 32'h100);
    chk("halt_redir_state", {31'b0, Halted}, 32'd1);
    chk("halt_redir_en", {31'b0, imem_en}, 32'd0);

    // Reset overrides a simultaneous Start
    reset = 1'b1; Start = 1'b1; cyc(); reset = 1'b0; Start = 1'b0;
    @(negedge clk);
    chk("rst2_halted", {31'b0, Halted}, 32'd0);
    chk("rst2_en", {31'b0, imem_en}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_valid", {31'b0, InstrValid}, 32'd0);
    cyc();
    @(negedge clk);
    chk("rst2_idle", {31'b0, imem_en}, 32'd0);

    // Halt with Redirect is wrong-path; then PC wrap at the top of memory
    push(32'h2000_0000, 32'd4);
    Start = 1'b1; cyc(); Start = 1'b0;
    cyc();
    cyc();
    Halt = 1'b1; Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
    @(negedge clk);
    chk("hr_en", {31'b0, imem_en}, 32'd0);
    cyc();
    Halt = 1'b0; Redirect = 1'b0;
    @(negedge clk);
    chk("hr_not_halted", {31'b0, Halted}, 32'd0);
    chk("hr_addr", imem_addr, 32'hFFFF_FFFC);
    chk("hr_en_run", {31'b0, imem_en}, 32'd1);
    chk("hr_valid", {31'b0, InstrValid}, 32'd0);
    push(32'h5FFF_FFFF, 32'h0);
    push(32'h2000_0000, 32'd4);
    cyc();
    @(negedge clk);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc();
    cyc();

    // Reset with a word in flight: it must never surface
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst3_valid", {31'b0, InstrValid}, 32'd0);
    chk("rst3_addr", imem_addr, 32'h0);
    chk("rst3_halted", {31'b0, Halted}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("rst3_discard", {31'b0, InstrValid}, 32'd0);
      chk("rst3_en", {31'b0, imem_en}, 32'd0);
    end

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
